// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle.
// Divide-by-zero and signed overflow finish through a one-step fast path.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2:0]         f3_q, f3_d;
    logic               fast_q, fast_d;
    logic               neg_q, neg_d;
    logic               sign_a_q, sign_a_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand decode for the request currently on the inputs.
    logic             is_div, a_signed, b_signed, sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b, fast_res;
    logic             div_zero, div_ovf;

    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        sign_a   = a_signed & op_a[WIDTH-1];
        sign_b   = b_signed & op_b[WIDTH-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && a_signed && (op_a == MinNeg) && (op_b == '1);
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) begin
            fast_res = funct3[1] ? op_a : '1;
        end else begin
            fast_res = funct3[1] ? '0 : MinNeg;
        end
    end

    // Single iteration step and final sign correction.
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   div_diff, quo, rem, res_fin;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_acc, prod_fin;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = rem_sh >= {1'b0, mag_b_q};
        // True difference always fits WIDTH bits because the remainder stays below the divisor
        div_diff = rem_sh[WIDTH-1:0] - mag_b_q;
        if (f3_q[2]) begin
            if (div_ge) begin
                step_acc = {div_diff, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
        end
        prod_fin = neg_q ? -step_acc : step_acc;
        quo      = step_acc[WIDTH-1:0];
        rem      = step_acc[2*WIDTH-1:WIDTH];
        unique case (f3_q)
            3'b000:                res_fin = prod_fin[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: res_fin = prod_fin[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:        res_fin = neg_q ? -quo : quo;
            default:               res_fin = sign_a_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        f3_d     = f3_q;
        fast_d   = fast_q;
        neg_d    = neg_q;
        sign_a_d = sign_a_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    f3_d     = funct3;
                    fast_d   = div_zero | div_ovf;
                    neg_d    = sign_a ^ sign_b;
                    sign_a_d = sign_a;
                    mag_a_d  = mag_a;
                    mag_b_d  = mag_b;
                    count_d  = '0;
                    // Multiplier or dividend sits in the low half and shifts out as the step runs
                    if (div_zero | div_ovf) begin
                        acc_d = {{WIDTH{1'b0}}, fast_res};
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
                    end
                    state_d = StCalc;
                    busy_d  = 1'b1;
                end
            end
            StCalc: begin
                if (fast_q) begin
                    result_d = acc_q[WIDTH-1:0];
                    state_d  = StDone;
                    done_d   = 1'b1;
                end else begin
                    acc_d   = step_acc;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        result_d = res_fin;
                        state_d  = StDone;
                        done_d   = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            f3_q     <= '0;
            fast_q   <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            f3_q     <= f3_d;
            fast_q   <= fast_d;
            neg_q    <= neg_d;
            sign_a_q <= sign_a_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, ignored starts and reset abort.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp;
    int n_err;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request (accepted at E0) and observe until busy drops or 40 edges pass.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int d_edge, output int d_cnt,
                         output int b_drop, output logic b0);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        b0     = busy;
        op_a   = ~a;
        op_b   = ~b;
        res    = 'x;
        d_edge = -1;
        d_cnt  = 0;
        b_drop = -1;
        for (int k = 1; k <= 40 && b_drop < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                d_cnt++;
                if (d_edge < 0) begin
                    d_edge = k;
                    res    = result;
                end
            end
            if (!busy) b_drop = k;
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        #12;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++;
        if (result !== 32'h0) begin
            n_err++; $display("FAIL reset_result got %h want 00000000", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        logic [31:0] r; int de, dc, bd; logic b0;
        do_op(3'b000, 32'd7, 32'hFFFFFFFD, r, de, dc, bd, b0);
        n_cmp++;
        if (r !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mul_result got %h want ffffffeb", r); end
        n_cmp++;
        if (b0 !== 1'b1) begin n_err++; $display("FAIL mul_busy_e0 got %b want 1", b0); end
        n_cmp++;
        if (de != 32) begin n_err++; $display("FAIL mul_done_edge got %0d want 32", de); end
        n_cmp++;
        if (dc != 1) begin n_err++; $display("FAIL mul_done_cycles got %0d want 1", dc); end
        n_cmp++;
        if (bd != 33) begin n_err++; $display("FAIL mul_busy_drop got %0d want 33", bd); end
    endtask

    task automatic test_mul_high;
        logic [2:0]  f[3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] a[3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b[3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e[3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] r; int de, dc, bd; logic b0;
        for (int i = 0; i < 3; i++) begin
            do_op(f[i], a[i], b[i], r, de, dc, bd, b0);
            n_cmp++;
            if (r !== e[i]) begin
                n_err++; $display("FAIL mulh_result[f3=%b] got %h want %h", f[i], r, e[i]);
            end
            n_cmp++;
            if (de != 32) begin
                n_err++; $display("FAIL mulh_done_edge[f3=%b] got %0d want 32", f[i], de);
            end
        end
    endtask

    task automatic test_divide;
        logic [2:0]  f[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] b[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] e[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0000000E, 32'h00000002};
        logic [31:0] r; int de, dc, bd; logic b0;
        for (int i = 0; i < 4; i++) begin
            do_op(f[i], a[i], b[i], r, de, dc, bd, b0);
            n_cmp++;
            if (r !== e[i]) begin
                n_err++; $display("FAIL div_result[f3=%b] got %h want %h", f[i], r, e[i]);
            end
            n_cmp++;
            if (de != 32) begin
                n_err++; $display("FAIL div_done_edge[f3=%b] got %0d want 32", f[i], de);
            end
        end
    endtask

    task automatic test_fast_path;
        logic [2:0]  f[5] = '{3'b100, 3'b110, 3'b101, 3'b100, 3'b110};
        logic [31:0] a[5] = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] b[5] = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e[5] = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'h80000000, 32'h0};
        logic [31:0] r; int de, dc, bd; logic b0;
        for (int i = 0; i < 5; i++) begin
            do_op(f[i], a[i], b[i], r, de, dc, bd, b0);
            n_cmp++;
            if (r !== e[i]) begin
                n_err++; $display("FAIL fast_result[%0d] got %h want %h", i, r, e[i]);
            end
            n_cmp++;
            if (de != 1 || dc != 1) begin
                n_err++; $display("FAIL fast_done[%0d] got edge %0d x%0d want edge 1 x1", i, de, dc);
            end
            n_cmp++;
            if (bd != 2) begin
                n_err++; $display("FAIL fast_busy_drop[%0d] got %0d want 2", i, bd);
            end
        end
    endtask

    task automatic test_start_ignored;
        int de = -1;
        logic [31:0] r = 'x;
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd7;
        op_b   = 32'hFFFFFFFD;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            start = (k == 4);
            if (k == 4) begin
                funct3 = 3'b011;
                op_a   = 32'd3;
                op_b   = 32'd4;
            end
            if (done && de < 0) begin
                de = k;
                r  = result;
            end
            if (k == 34) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++; $display("FAIL ignored_start_busy_e34 got %b want 0", busy);
                end
            end
        end
        n_cmp++;
        if (r !== 32'hFFFFFFEB) begin
            n_err++; $display("FAIL ignored_start_result got %h want ffffffeb", r);
        end
        n_cmp++;
        if (de != 32) begin n_err++; $display("FAIL ignored_start_done_edge got %0d want 32", de); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; int de, dc, bd; logic b0;
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd9;
        op_b   = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrst_flags got busy %b done %b want 0 0", busy, done);
        end
        n_cmp++;
        if (result !== 32'h0) begin
            n_err++; $display("FAIL midrst_result got %h want 00000000", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b000, 32'd3, 32'd4, r, de, dc, bd, b0);
        n_cmp++;
        if (r !== 32'h0000000C) begin
            n_err++; $display("FAIL midrst_mul_result got %h want 0000000c", r);
        end
        n_cmp++;
        if (de != 32 || bd != 33) begin
            n_err++; $display("FAIL midrst_mul_timing got done %0d drop %0d want 32 33", de, bd);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_mul();
        test_mul_high();
        test_divide();
        test_fast_path();
        test_start_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
